l0_cache_maint_sequencer: RTL and testbench
===========================================

# l0_cache_maint_sequencer

Sequencer that owns every valid-bit invalidation for the L0 data cache: the power-on clear sweep, full-cache flush requests (FENCE / external coherence) and, optionally, single-line invalidations by address. Sits beside the cache write controller. It drives the valid-RAM maintenance write port and stalls the pipeline while a flush is in progress. It yields to normal cache writes cycle by cycle, so no in-flight store/AMO/refill write is ever dropped.

## Interface
Parameters:
- CACHE_DEPTH, 128, number of cache entries (power of two, ≥2)
- MEM_BYTE_ADDR_WIDTH, 16, byte-address width covered by the cache
- XLEN, 32, address/data width

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_flush_req  in  1  full-flush request (valid)
- i_inval_req  in  1  single-line invalidate request (valid)
- i_inval_addr  in  XLEN  byte address for i_inval_req
- o_req_ready  out  1  request accepted when (i_flush_req|i_inval_req)&o_req_ready
- i_write_port_busy  in  1  cache write controller writing this cycle
- o_inval_we  out  1  valid-RAM clear strobe (all bytes of entry)
- o_inval_index  out  $clog2(CACHE_DEPTH)  entry to clear
- o_stall  out  1  pipeline stall request
- o_reset_in_progress  out  1  power-on sweep active; hit logic must report miss
- o_done  out  1  one-cycle pulse when an accepted request completes

## Operation
- States: RESET_SWEEP, IDLE, FLUSH_SWEEP, SINGLE.
- i_rst high: state=RESET_SWEEP, index=0. Reset values: o_reset_in_progress=1, o_req_ready=0, o_stall=0, o_done=0, o_inval_index=0, o_inval_we=1.
- RESET_SWEEP: o_inval_we=1 every cycle, ignores i_write_port_busy. Index increments each cycle. After the write of index CACHE_DEPTH-1 → IDLE, index=0.
- IDLE: o_req_ready=1, o_inval_we=0.
  - Flush accepted → FLUSH_SWEEP.
  - Inval accepted → SINGLE, latching index = i_inval_addr[2 +: IW]. No tag compare; invalidation is conservative.
  - Both valid in the same cycle: flush wins, and both are acknowledged (inval subsumed).
- FLUSH_SWEEP: o_stall=1.
  - o_inval_we = ~i_write_port_busy. Index advances only on a write.
  - After the write of CACHE_DEPTH-1 → IDLE with o_done=1 that cycle.
- SINGLE: o_inval_we = ~i_write_port_busy. Held until the write happens, then → IDLE with o_done=1. o_stall=0.
- o_req_ready=0 in all states except IDLE. Requesters hold valid until accepted.
- i_rst asserted mid-flush aborts it: no o_done, restart in RESET_SWEEP.
- Index arithmetic is IW bits wide. Terminal detection compares against CACHE_DEPTH-1, not against wrap to zero.

## Timing
- All outputs are combinational from registered state plus i_write_port_busy. There is no input-to-output path from the request inputs.
- Reset sweep: o_reset_in_progress falls exactly CACHE_DEPTH cycles after the first cycle with i_rst low.
- Flush accepted at edge T, no busy cycles:
  - writes in cycles T+1 … T+CACHE_DEPTH;
  - o_done and o_req_ready=1 in cycle T+CACHE_DEPTH+1.
  - Each busy cycle adds one.
- Single inval accepted at T: write at T+1 if not busy; o_done at T+2.
- Back-to-back: a new request can be accepted in the o_done cycle.

## Configuration
- L0_CACHE_SELECTIVE_INVAL_EN defined: i_inval_req/i_inval_addr are functional and the SINGLE state exists.
- Undefined: the SINGLE state is removed, and i_inval_req is ignored (never acknowledged; ready still reflects flush only). Ports remain present for a stable interface.

## Structure
- riscv_pkg: l0_maint_state_e enum. Parameters are passed from l0_cache; no new package constants.
- No sub-module. The sweep counter and FSM are inline.
- l0_cache instantiates this block in place of its local reset counter. It ORs o_inval_we into the valid-RAM write enable with write data 0 when o_inval_we.

## Test plan
- Reset, CACHE_DEPTH=8: i_rst for 3 cycles, then low → o_inval_we high with index 0..7 over 8 cycles; o_reset_in_progress drops in cycle 8; o_req_ready=1.
- Flush at T, no busy → o_stall high T+1..T+8, indices 0..7, o_done at T+9.
- Flush with i_write_port_busy high for cycles T+3 and T+4 → no write those cycles, index holds at 2, o_done at T+11.
- i_flush_req and i_inval_req (addr 0x0014) in the same cycle → both acknowledged; full sweep runs, no SINGLE state entered.
- Macro defined, inval addr 0x0014 → o_inval_index=5 at T+1, o_done at T+2, o_stall stays 0. Macro undefined → o_req_ready stays 1 and nothing is written.
- i_rst raised at flush index 4 → no o_done; restart sweep from 0 with o_reset_in_progress=1.

Source files
------------

// File: rtl/l0_cache_maint_sequencer_pkg.sv
// Shared types for the L0 cache maintenance sequencer.
// Optional feature macro: L0_CACHE_SELECTIVE_INVAL_EN (adds the SINGLE state).
package l0_cache_maint_sequencer_pkg;

   // Sequencer states; SINGLE only exists when selective invalidation is built in.
   typedef enum logic [1:0] {
      L0_RESET_SWEEP = 2'd0,
      L0_IDLE        = 2'd1,
      L0_FLUSH_SWEEP = 2'd2
`ifdef L0_CACHE_SELECTIVE_INVAL_EN
      ,
      L0_SINGLE      = 2'd3
`endif
   } l0_maint_state_e;

endpackage

// File: rtl/l0_cache_maint_sequencer.sv
// L0 data-cache valid-bit maintenance sequencer: power-on clear sweep,
// full flush sweep and (optionally) single-line invalidation by address.
// Yields the valid-RAM port to the cache write controller cycle by cycle
// during flush / single invalidation; the power-on sweep never yields.
// Optional feature macro: L0_CACHE_SELECTIVE_INVAL_EN
//   defined   : i_inval_req / i_inval_addr functional, SINGLE state present
//   undefined : i_inval_req ignored, ports kept for a stable interface
module l0_cache_maint_sequencer
   import l0_cache_maint_sequencer_pkg::*;
#(
   parameter int CACHE_DEPTH         = 128,
   parameter int MEM_BYTE_ADDR_WIDTH = 16,
   parameter int XLEN                = 32
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_flush_req,
   input  logic                           i_inval_req,
   input  logic [XLEN-1:0]                i_inval_addr,
   output logic                           o_req_ready,
   input  logic                           i_write_port_busy,
   output logic                           o_inval_we,
   output logic [$clog2(CACHE_DEPTH)-1:0] o_inval_index,
   output logic                           o_stall,
   output logic                           o_reset_in_progress,
   output logic                           o_done
);

   localparam int            IW       = $clog2(CACHE_DEPTH);
   localparam logic [IW-1:0] LAST_IDX = IW'(CACHE_DEPTH - 1);

   l0_maint_state_e state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            done_q, done_d;

   // Line index of an invalidation address: word-granular entries, so the
   // two byte-offset bits are skipped. No tag compare is done.
   logic [MEM_BYTE_ADDR_WIDTH-1:0] line_addr;
   logic                           inval_take;
   logic [IW-1:0]                  inval_idx;
   logic                           unused_inval_bits;

   assign line_addr = i_inval_addr[MEM_BYTE_ADDR_WIDTH-1:0];
   assign inval_idx = line_addr[2 +: IW];

`ifdef L0_CACHE_SELECTIVE_INVAL_EN
   assign inval_take        = i_inval_req;
   assign unused_inval_bits = ^{i_inval_addr};
`else
   assign inval_take        = 1'b0;
   assign unused_inval_bits = ^{i_inval_req, i_inval_addr, line_addr, inval_idx};
`endif

   // State, sweep index and completion pulse registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= L0_RESET_SWEEP;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   // Next-state and outputs; outputs depend only on registered state and
   // i_write_port_busy, never on the request inputs.
   always_comb begin
      state_d             = state_q;
      idx_d               = idx_q;
      done_d              = 1'b0;
      o_inval_we          = 1'b0;
      o_stall             = 1'b0;
      o_req_ready         = 1'b0;
      o_reset_in_progress = 1'b0;
      case (state_q)
         L0_RESET_SWEEP: begin
            o_inval_we          = 1'b1;
            o_reset_in_progress = 1'b1;
            if (idx_q == LAST_IDX) begin
               state_d = L0_IDLE;
               idx_d   = '0;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         L0_IDLE: begin
            o_req_ready = 1'b1;
            // Flush has priority; a simultaneous invalidate is subsumed by it.
            if (i_flush_req) begin
               state_d = L0_FLUSH_SWEEP;
               idx_d   = '0;
            end
`ifdef L0_CACHE_SELECTIVE_INVAL_EN
            else if (inval_take) begin
               state_d = L0_SINGLE;
               idx_d   = inval_idx;
            end
`endif
         end
         L0_FLUSH_SWEEP: begin
            o_stall    = 1'b1;
            o_inval_we = ~i_write_port_busy;
            if (!i_write_port_busy) begin
               if (idx_q == LAST_IDX) begin
                  state_d = L0_IDLE;
                  idx_d   = '0;
                  done_d  = 1'b1;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
`ifdef L0_CACHE_SELECTIVE_INVAL_EN
         L0_SINGLE: begin
            o_inval_we = ~i_write_port_busy;
            if (!i_write_port_busy) begin
               state_d = L0_IDLE;
               idx_d   = '0;
               done_d  = 1'b1;
            end
         end
`endif
         default: begin
            state_d = L0_RESET_SWEEP;
            idx_d   = '0;
         end
      endcase
   end

   assign o_done        = done_q;
   assign o_inval_index = idx_q;

endmodule

// File: tb/tb_l0_cache_maint_sequencer.sv
// Directed, table-driven bench for l0_cache_maint_sequencer (CACHE_DEPTH=8).
module tb_l0_cache_maint_sequencer;

   localparam int DEPTH = 8;
   localparam int IW    = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush_req;
   logic          inval_req;
   logic [31:0]   inval_addr;
   logic          req_ready;
   logic          busy;
   logic          inval_we;
   logic [IW-1:0] inval_index;
   logic          stall;
   logic          rip;
   logic          done;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   l0_cache_maint_sequencer #(
      .CACHE_DEPTH(DEPTH),
      .MEM_BYTE_ADDR_WIDTH(16),
      .XLEN(32)
   ) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_flush_req(flush_req),
      .i_inval_req(inval_req),
      .i_inval_addr(inval_addr),
      .o_req_ready(req_ready),
      .i_write_port_busy(busy),
      .o_inval_we(inval_we),
      .o_inval_index(inval_index),
      .o_stall(stall),
      .o_reset_in_progress(rip),
      .o_done(done)
   );

   typedef struct {
      logic        rst;
      logic        flush;
      logic        inval;
      logic [31:0] addr;
      logic        busy;
      logic        we;
      int          idx;
      logic        chk_idx;
      logic        stall;
      logic        rip;
      logic        ready;
      logic        done;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic f, input logic iv, input logic [31:0] a,
                      input logic b, input logic we, input int idx, input logic ci,
                      input logic st, input logic rp, input logic rd, input logic dn);
      vec_t v;
      v.rst = r; v.flush = f; v.inval = iv; v.addr = a; v.busy = b;
      v.we = we; v.idx = idx; v.chk_idx = ci; v.stall = st; v.rip = rp;
      v.ready = rd; v.done = dn;
      vecs.push_back(v);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic f, input logic iv,
                        input logic [31:0] a, input logic b);
      rst = r; flush_req = f; inval_req = iv; inval_addr = a; busy = b;
   endtask

   initial begin
      int cnt;
      // Reset held: 3 cycles, then the 8-entry power-on sweep.
      for (int i = 0; i < 3; i++) add(1,0,0,0,0, 1,0,1, 0,1,0,0);
      for (int k = 0; k < DEPTH; k++) add(0,0,0,0,0, 1,k,1, 0,1,0,0);
      // Idle, flush accepted at the end of this cycle.
      add(0,1,0,0,0, 0,0,1, 0,0,1,0);
      for (int k = 0; k < DEPTH; k++) add(0,0,0,0,0, 1,k,1, 1,0,0,0);
      // Done cycle, back-to-back flush accepted; busy on sweep cycles 3 and 4.
      add(0,1,0,0,0, 0,0,1, 0,0,1,1);
      for (int c = 1; c <= 10; c++) begin
         logic b;
         int   ix;
         b  = (c == 3) || (c == 4);
         ix = (c <= 2) ? c - 1 : ((c <= 4) ? 2 : c - 3);
         add(0,0,0,0,b, !b,ix,1, 1,0,0,0);
      end
      add(0,0,0,0,0, 0,0,1, 0,0,1,1);
      // Flush and invalidate together: full sweep from 0, no single-line step.
      add(0,1,1,32'h14,0, 0,0,1, 0,0,1,0);
      for (int k = 0; k < DEPTH; k++) add(0,0,0,0,0, 1,k,1, 1,0,0,0);
      add(0,0,0,0,0, 0,0,1, 0,0,1,1);
`ifdef L0_CACHE_SELECTIVE_INVAL_EN
      // Single invalidate with one busy cycle, then one without.
      add(0,0,1,32'h14,0, 0,0,1, 0,0,1,0);
      add(0,0,0,0,1, 0,5,1, 0,0,0,0);
      add(0,0,0,0,0, 1,5,1, 0,0,0,0);
      add(0,0,1,32'h14,0, 0,0,0, 0,0,1,1);
      add(0,0,0,0,0, 1,5,1, 0,0,0,0);
      add(0,0,0,0,0, 0,0,0, 0,0,1,1);
`else
      // Invalidate ignored: ready stays high, nothing written, no done.
      for (int i = 0; i < 4; i++) add(0,0,1,32'h14,0, 0,0,1, 0,0,1,0);
`endif
      add(0,0,0,0,0, 0,0,0, 0,0,1,0);

      drive(1,0,0,0,0);
      @(posedge clk);
      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].rst, vecs[i].flush, vecs[i].inval, vecs[i].addr, vecs[i].busy);
         #1;
         chk($sformatf("v%0d.we", i),    int'(inval_we),  int'(vecs[i].we));
         if (vecs[i].chk_idx)
            chk($sformatf("v%0d.idx", i), int'(inval_index), vecs[i].idx);
         chk($sformatf("v%0d.stall", i), int'(stall),     int'(vecs[i].stall));
         chk($sformatf("v%0d.rip", i),   int'(rip),       int'(vecs[i].rip));
         chk($sformatf("v%0d.ready", i), int'(req_ready), int'(vecs[i].ready));
         chk($sformatf("v%0d.done", i),  int'(done),      int'(vecs[i].done));
      end

      // Reset raised mid-flush at index 4: no done, sweep restarts from 0.
      @(negedge clk);
      drive(0,1,0,0,0);
      #1;
      chk("abort.ready", int'(req_ready), 1);
      @(negedge clk);
      drive(0,0,0,0,0);
      #1;
      cnt = 0;
      while (!(inval_we && inval_index == 3'd4) && cnt < 20) begin
         chk("abort.no_done_pre", int'(done), 0);
         @(negedge clk);
         #1;
         cnt++;
      end
      chk("abort.reached_idx4", int'(inval_index), 4);
      chk("abort.stall_at4", int'(stall), 1);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("abort.rst_rip", int'(rip), 1);
      chk("abort.rst_idx", int'(inval_index), 0);
      chk("abort.rst_we", int'(inval_we), 1);
      chk("abort.rst_stall", int'(stall), 0);
      chk("abort.rst_ready", int'(req_ready), 0);
      chk("abort.rst_done", int'(done), 0);
      rst = 1'b0;
      cnt = 0;
      while (rip && cnt < 20) begin
         chk($sformatf("abort.sweep_idx%0d", cnt), int'(inval_index), cnt);
         chk("abort.sweep_done", int'(done), 0);
         @(negedge clk);
         #1;
         cnt++;
      end
      chk("abort.sweep_len", cnt, DEPTH);
      chk("abort.idle_ready", int'(req_ready), 1);
      chk("abort.idle_done", int'(done), 0);
      chk("abort.idle_we", int'(inval_we), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
